// File: rtl/register_file_read.sv
// register_file_read
// Decode-stage register file: DEPTH word registers, one synchronous write
// port driven by write-back and two combinational read ports (rs, rt).
// Register 0 is hardwired to zero and the stack pointer resets to SP_START.
// With BYPASS=1 a write presented in the same cycle as a read of the same
// register is forwarded straight to the read port, avoiding a stall.

module register_file_read #(
   parameter int          N        = 32,
   parameter int          ADDR     = 5,
   parameter logic [N-1:0] START   = '0,
   parameter int          SP_INDEX = 29,
   parameter logic [31:0] SP_START = 32'h7FFF_EFFC,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RegWrite,
   input  logic [ADDR-1:0] WriteRegister,
   input  logic [N-1:0]    WriteData,
   input  logic [ADDR-1:0] ReadRegister1,
   input  logic [ADDR-1:0] ReadRegister2,
   output logic [N-1:0]    ReadData1,
   output logic [N-1:0]    ReadData2
);

   localparam int DEPTH = 2 ** ADDR;

   // SP_START is truncated or zero-extended to the word width.
   localparam logic [N-1:0] SP_VAL = N'(SP_START);

   logic [N-1:0]     regs [DEPTH];
   logic [DEPTH-1:0] write_en;
   logic             bypass_ok;

   // Reset value of each register; index 0 takes priority so it is always zero.
   function automatic logic [N-1:0] reset_value(input int idx);
      if (idx == 0) begin
         return '0;
      end else if (idx == SP_INDEX) begin
         return SP_VAL;
      end else begin
         return START;
      end
   endfunction

   // One-hot write decoder; register 0 never gets an enable, so writes to it vanish.
   always_comb begin
      write_en = '0;
      for (int i = 1; i < DEPTH; i++) begin
         if (RegWrite && (WriteRegister == ADDR'(i))) begin
            write_en[i] = 1'b1;
         end
      end
   end

   // Enable-gated register bank; the async reset overrides any pending write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= reset_value(i);
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (write_en[i]) begin
               regs[i] <= WriteData;
            end
         end
      end
   end

   // Forwarding is only legal for a real write outside reset.
   always_comb begin
      bypass_ok = BYPASS && RegWrite && !reset && (WriteRegister != '0);
   end

   // rs read port: zero register first, then forwarding, then stored contents.
   always_comb begin
      ReadData1 = regs[ReadRegister1];
      if (ReadRegister1 == '0) begin
         ReadData1 = '0;
      end else if (bypass_ok && (ReadRegister1 == WriteRegister)) begin
         ReadData1 = WriteData;
      end
   end

   // rt read port: same priority as rs, fully independent of it.
   always_comb begin
      ReadData2 = regs[ReadRegister2];
      if (ReadRegister2 == '0) begin
         ReadData2 = '0;
      end else if (bypass_ok && (ReadRegister2 == WriteRegister)) begin
         ReadData2 = WriteData;
      end
   end

endmodule

// File: tb/tb_register_file_read.sv
// tb_register_file_read
// Drives a forwarding and a non-forwarding register file with the same
// stimulus; expected read data comes from an array model of the register
// file and is queued for a separate monitor to compare.

module tb_register_file_read;

   localparam logic [31:0] SP_RESET = 32'h7FFF_EFFC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        RegWrite = 1'b0;
   logic [4:0]  WriteRegister = '0;
   logic [31:0] WriteData = '0;
   logic [4:0]  ReadRegister1 = '0;
   logic [4:0]  ReadRegister2 = '0;
   logic [31:0] rd1_byp, rd2_byp, rd1_nob, rd2_nob;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      string       name;
      logic [31:0] e1b;
      logic [31:0] e2b;
      logic [31:0] e1n;
      logic [31:0] e2n;
   } exp_t;

   exp_t        sbq[$];
   logic        check_strobe = 1'b0;
   logic [31:0] model [32];

   register_file_read #(.BYPASS(1'b1)) dut_byp (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .WriteRegister(WriteRegister), .WriteData(WriteData),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(rd1_byp), .ReadData2(rd2_byp)
   );

   register_file_read #(.BYPASS(1'b0)) dut_nob (
      .clk(clk), .reset(reset), .RegWrite(RegWrite),
      .WriteRegister(WriteRegister), .WriteData(WriteData),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(rd1_nob), .ReadData2(rd2_nob)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Architectural reset contents of the register file.
   task automatic modelReset();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[29] = SP_RESET;
   endtask

   // What a read should return given the currently driven write-port inputs.
   function automatic logic [31:0] expRead(input logic [4:0] addr, input bit fwd);
      if (addr == 5'd0) return 32'h0;
      if (fwd && RegWrite && !reset && WriteRegister != 5'd0 && addr == WriteRegister)
         return WriteData;
      return model[addr];
   endfunction

   // Queue the expected outputs for the current inputs and wake the monitor.
   task automatic pushCheck(input string name);
      exp_t e;
      e.name = name;
      e.e1b  = expRead(ReadRegister1, 1'b1);
      e.e2b  = expRead(ReadRegister2, 1'b1);
      e.e1n  = expRead(ReadRegister1, 1'b0);
      e.e2n  = expRead(ReadRegister2, 1'b0);
      sbq.push_back(e);
      check_strobe = ~check_strobe;
      #1;
   endtask

   // One full cycle: drive at negedge, check before the rising edge, then
   // let the edge commit the write in the model.
   task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wr,
                                input logic [31:0] wd, input logic [4:0] r1,
                                input logic [4:0] r2, input string name);
      @(negedge clk);
      reset = rst;
      RegWrite = we;
      WriteRegister = wr;
      WriteData = wd;
      ReadRegister1 = r1;
      ReadRegister2 = r2;
      if (rst) modelReset();
      #1;
      pushCheck(name);
      @(posedge clk);
      if (!reset && RegWrite && WriteRegister != 5'd0) model[WriteRegister] = WriteData;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per strobe and compares all four read ports.
   initial begin
      exp_t e;
      forever begin
         @(check_strobe);
         if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_underflow: got 0 entries expected 1");
         end else begin
            e = sbq.pop_front();
            checkOutput({e.name, "/rd1_byp"}, rd1_byp, e.e1b);
            checkOutput({e.name, "/rd2_byp"}, rd2_byp, e.e2b);
            checkOutput({e.name, "/rd1_nob"}, rd1_nob, e.e1n);
            checkOutput({e.name, "/rd2_nob"}, rd2_nob, e.e2n);
         end
      end
   end

   // Stimulus: directed plan followed by randomized traffic.
   initial begin
      logic        we;
      logic [4:0]  wr, r1, r2;
      logic [31:0] wd;
      modelReset();

      // Reset state, including a write attempt that must be ignored.
      applyStimulus(1'b1, 1'b1, 5'd5, 32'h1234_5678, 5'd0, 5'd29, "rst_r0_r29");
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd29, "rst_r5");
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd29, "post_rst_r0_r29");
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "post_rst_r5");

      // Basic write then read on both ports.
      applyStimulus(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd9, "wr_r8");
      applyStimulus(1'b0, 1'b0, 5'd8, 32'h0, 5'd8, 5'd8, "rd_r8");
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, "rd_r9");

      // Register 0 stays zero, even while being written.
      applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "wr_r0");
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8, "rd_r0");

      // Forwarding versus stored contents on r10.
      applyStimulus(1'b0, 1'b1, 5'd10, 32'h1111, 5'd0, 5'd0, "wr_r10_a");
      applyStimulus(1'b0, 1'b1, 5'd10, 32'h2222, 5'd10, 5'd10, "bypass_r10");
      applyStimulus(1'b0, 1'b0, 5'd10, 32'h0, 5'd10, 5'd8, "rd_r10");

      // Write enable low: r12 must not change.
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b0, 5'd12, 32'hABCD + 32'(i), 5'd12, 5'd12, "gate_r12");
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, "rd_r12");

      // Asynchronous reset pulse between edges while a write is pending.
      applyStimulus(1'b0, 1'b1, 5'd4, 32'h55, 5'd0, 5'd0, "wr_r4");
      applyStimulus(1'b0, 1'b1, 5'd29, 32'h1000, 5'd4, 5'd0, "wr_r29");
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd29, "rd_r4_r29");
      @(negedge clk);
      RegWrite = 1'b1;
      WriteRegister = 5'd4;
      WriteData = 32'h66;
      ReadRegister1 = 5'd4;
      ReadRegister2 = 5'd29;
      #1;
      reset = 1'b1;
      modelReset();
      #1;
      pushCheck("async_rst_during");
      reset = 1'b0;
      RegWrite = 1'b0;
      #1;
      pushCheck("async_rst_after");
      @(posedge clk);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd29, "rd_r4_dropped");
      applyStimulus(1'b0, 1'b1, 5'd4, 32'h77, 5'd4, 5'd0, "wr_r4_77");
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, "rd_r4_77");

      // Random traffic, biased so read addresses often collide with the write.
      for (int n = 0; n < 300; n++) begin
         we = ($urandom_range(0, 3) != 0);
         wr = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) wr = 5'd0;
         wd = $urandom;
         r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 9) == 0) r2 = r1;
         applyStimulus(1'b0, we, wr, wd, r1, r2, "random");
      end

      #3;
      compared++;
      if (sbq.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
